// File: rtl/param_frame_serializer_if.sv
// ----------------------------------------------------------------------------
// param_frame_serializer_if
//   Bundles the load handshake, bit-rate tick and serial outputs of the
//   frame serializer so that source and serializer connect through one port.
//
//   Signals
//     P_DATA      parallel payload from the TX FSM/FIFO
//     data_valid  load request
//     ser_ready   serializer idle, load accepted when data_valid && ser_ready
//     shift_en    bit-period tick
//     ser_data    current serial bit, 1 when idle
//     par_bit     parity of the last accepted payload
//     busy        frame in progress
//     ser_done    one-cycle pulse after the last bit period
//
//   Modports
//     master  payload source / tick generator side
//     slave   serializer side
// ----------------------------------------------------------------------------
interface param_frame_serializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  ser_ready;
    logic                  shift_en;
    logic                  ser_data;
    logic                  par_bit;
    logic                  busy;
    logic                  ser_done;

    modport master (
        output P_DATA,
        output data_valid,
        output shift_en,
        input  ser_ready,
        input  ser_data,
        input  par_bit,
        input  busy,
        input  ser_done
    );

    modport slave (
        input  P_DATA,
        input  data_valid,
        input  shift_en,
        output ser_ready,
        output ser_data,
        output par_bit,
        output busy,
        output ser_done
    );

endinterface

// File: rtl/param_frame_serializer.sv
// ----------------------------------------------------------------------------
// param_frame_serializer
//   Parallel-to-serial converter for the UART TX datapath. A payload of
//   DATA_WIDTH bits is accepted through a ready/valid handshake and shifted
//   out one bit per shift_en tick, LSB or MSB first. The payload parity is
//   registered on load for the TX frame FSM to insert into the line.
//
//   Parameters
//     DATA_WIDTH  payload bits per frame (2..32)
//     MSB_FIRST   0: LSB transmitted first, 1: MSB transmitted first
//     PARITY_ODD  0: even parity, 1: odd parity
//
//   Ports
//     CLK   clock, rising edge
//     RST   synchronous reset, active-high, overrides all other inputs
//     bus   slave side of param_frame_serializer_if
//             in : P_DATA, data_valid, shift_en
//             out: ser_ready, ser_data, par_bit, busy, ser_done
// ----------------------------------------------------------------------------
module param_frame_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RST,
    param_frame_serializer_if.slave  bus
);

    localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DATA_WIDTH - 1);
    // Position of the bit currently presented on the line.
    localparam int unsigned OutIdx = MSB_FIRST ? DATA_WIDTH - 1 : 0;

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;
    logic                   par_q,   par_d;
    logic                   done_q,  done_d;
    logic [DATA_WIDTH-1:0]  shifted;

    // Shift one position toward the output end, zero fill behind.
    always_comb begin
        shifted = '0;
        if (MSB_FIRST) begin
            shifted = {shift_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shift_q[DATA_WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // shift_en is deliberately ignored here, including on the load edge.
                if (bus.data_valid) begin
                    shift_d = bus.P_DATA;
                    cnt_d   = '0;
                    par_d   = (^bus.P_DATA) ^ PARITY_ODD;
                    state_d = StShift;
                end
            end
            StShift: begin
                // data_valid is ignored for the whole frame.
                if (bus.shift_en) begin
                    if (cnt_q == CntLast) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        shift_d = '0;
                        cnt_d   = '0;
                    end else begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registers only
    // ------------------------------------------------------------------
    assign bus.busy      = (state_q == StShift);
    assign bus.ser_ready = (state_q == StIdle);
    assign bus.ser_data  = (state_q == StShift) ? shift_q[OutIdx] : 1'b1;
    assign bus.par_bit   = par_q;
    assign bus.ser_done  = done_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_cnt_bound : assert property (@(posedge CLK) cnt_q <= CntLast);
    a_done_idle : assert property (@(posedge CLK) done_q |-> (state_q == StIdle));

endmodule

// File: tb/tb_param_frame_serializer.sv
// ----------------------------------------------------------------------------
// tb_param_frame_serializer
//   Three serializer instances share one stimulus stream:
//     u0: 8 bits, LSB first, even parity
//     u1: 8 bits, MSB first, odd parity
//     u2: 5 bits, LSB first, even parity (low 5 bits of the payload)
//   A frame-level reference model predicts every output every cycle.
// ----------------------------------------------------------------------------
module tb_param_frame_serializer;

    localparam int NInst = 3;

    logic        CLK = 1'b0;
    logic        tb_rst;
    logic        tb_valid;
    logic        tb_tick;
    logic [31:0] tb_data;

    always #5 CLK = ~CLK;

    param_frame_serializer_if #(.DATA_WIDTH(8)) if0 ();
    param_frame_serializer_if #(.DATA_WIDTH(8)) if1 ();
    param_frame_serializer_if #(.DATA_WIDTH(5)) if2 ();

    assign if0.P_DATA = tb_data[7:0];
    assign if1.P_DATA = tb_data[7:0];
    assign if2.P_DATA = tb_data[4:0];
    assign if0.data_valid = tb_valid;
    assign if1.data_valid = tb_valid;
    assign if2.data_valid = tb_valid;
    assign if0.shift_en = tb_tick;
    assign if1.shift_en = tb_tick;
    assign if2.shift_en = tb_tick;

    param_frame_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .PARITY_ODD(1'b0)) u0 (
        .CLK (CLK),
        .RST (tb_rst),
        .bus (if0)
    );
    param_frame_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .PARITY_ODD(1'b1)) u1 (
        .CLK (CLK),
        .RST (tb_rst),
        .bus (if1)
    );
    param_frame_serializer #(.DATA_WIDTH(5), .MSB_FIRST(1'b0), .PARITY_ODD(1'b0)) u2 (
        .CLK (CLK),
        .RST (tb_rst),
        .bus (if2)
    );

    logic got_data[NInst];
    logic got_ready[NInst];
    logic got_busy[NInst];
    logic got_done[NInst];
    logic got_par[NInst];

    assign got_data[0]  = if0.ser_data;
    assign got_data[1]  = if1.ser_data;
    assign got_data[2]  = if2.ser_data;
    assign got_ready[0] = if0.ser_ready;
    assign got_ready[1] = if1.ser_ready;
    assign got_ready[2] = if2.ser_ready;
    assign got_busy[0]  = if0.busy;
    assign got_busy[1]  = if1.busy;
    assign got_busy[2]  = if2.busy;
    assign got_done[0]  = if0.ser_done;
    assign got_done[1]  = if1.ser_done;
    assign got_done[2]  = if2.ser_done;
    assign got_par[0]   = if0.par_bit;
    assign got_par[1]   = if1.par_bit;
    assign got_par[2]   = if2.par_bit;

    // ------------------------------------------------------------------
    // Reference model: a frame is a payload plus the index of the bit
    // being transmitted; the line bit is picked straight from the payload.
    // ------------------------------------------------------------------
    int unsigned cfg_w[NInst]   = '{8, 8, 5};
    bit          cfg_msb[NInst] = '{1'b0, 1'b1, 1'b0};
    bit          cfg_odd[NInst] = '{1'b0, 1'b1, 1'b0};

    bit          m_busy[NInst];
    logic [31:0] m_pay[NInst];
    int unsigned m_k[NInst];
    bit          m_par[NInst];
    bit          m_done[NInst];

    int n_pass  = 0;
    int n_check = 0;

    function automatic logic [31:0] width_mask(input int unsigned w);
        if (w >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic bit exp_line(input int i);
        int unsigned pos;
        if (!m_busy[i]) return 1'b1;
        pos = cfg_msb[i] ? (cfg_w[i] - 1 - m_k[i]) : m_k[i];
        return m_pay[i][pos];
    endfunction

    task automatic model_step();
        for (int i = 0; i < NInst; i++) begin
            if (tb_rst) begin
                m_busy[i] = 1'b0;
                m_pay[i]  = '0;
                m_k[i]    = 0;
                m_par[i]  = 1'b0;
                m_done[i] = 1'b0;
            end else begin
                m_done[i] = 1'b0;
                if (!m_busy[i]) begin
                    if (tb_valid) begin
                        m_busy[i] = 1'b1;
                        m_pay[i]  = tb_data & width_mask(cfg_w[i]);
                        m_k[i]    = 0;
                        m_par[i]  = (^m_pay[i]) ^ cfg_odd[i];
                    end
                end else if (tb_tick) begin
                    if (m_k[i] == cfg_w[i] - 1) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end else begin
                        m_k[i] = m_k[i] + 1;
                    end
                end
            end
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_check++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NInst; i++) begin
            check_bit($sformatf("u%0d.ser_data", i),  got_data[i],  exp_line(i));
            check_bit($sformatf("u%0d.ser_ready", i), got_ready[i], !m_busy[i]);
            check_bit($sformatf("u%0d.busy", i),      got_busy[i],  m_busy[i]);
            check_bit($sformatf("u%0d.ser_done", i),  got_done[i],  m_done[i]);
            check_bit($sformatf("u%0d.par_bit", i),   got_par[i],   m_par[i]);
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare after the edge.
    task automatic cycle(input logic rst, input logic valid, input logic [31:0] data,
                         input logic tick);
        @(negedge CLK);
        tb_rst   = rst;
        tb_valid = valid;
        tb_data  = data;
        tb_tick  = tick;
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
    endtask

    logic [7:0] seq_lsb;
    logic [7:0] seq_msb;
    int         mode;

    initial begin
        tb_rst   = 1'b1;
        tb_valid = 1'b0;
        tb_tick  = 1'b0;
        tb_data  = '0;
        seq_lsb  = 8'hC1;  // bit i = i-th transmitted bit, LSB first
        seq_msb  = 8'h83;  // 8'hC1 bit-reversed, MSB first

        // Reset held two cycles, then released.
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'hFF, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check_bit("rst.ser_data", got_data[0], 1'b1);
        check_bit("rst.par_bit",  got_par[0],  1'b0);

        // 8'hC1 with shift_en every cycle; tick on the load edge is ignored.
        cycle(1'b0, 1'b1, 32'hC1, 1'b1);
        check_bit("c1.lsb_bit", got_data[0], seq_lsb[0]);
        check_bit("c1.msb_bit", got_data[1], seq_msb[0]);
        check_bit("c1.par_even", got_par[0], 1'b1);
        check_bit("c1.par_odd",  got_par[1], 1'b0);
        for (int b = 1; b < 8; b++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            check_bit("c1.lsb_bit", got_data[0], seq_lsb[b]);
            check_bit("c1.msb_bit", got_data[1], seq_msb[b]);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check_bit("c1.end_line", got_data[0], 1'b1);
        check_bit("c1.end_done", got_done[0], 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check_bit("c1.done_pulse", got_done[0], 1'b0);

        // 8'h55 with a tick every 4th cycle and a mid-frame load attempt.
        cycle(1'b0, 1'b1, 32'h55, 1'b0);
        for (int c = 0; c < 32; c++) begin
            cycle(1'b0, (c == 10), (c == 10) ? 32'hFF : 32'h0, ((c % 4) == 3));
        end
        check_bit("slow.done_32", got_done[0], 1'b1);

        // Back-to-back: load 8'h0F in the ser_done cycle.
        cycle(1'b0, 1'b1, 32'h0F, 1'b1);
        check_bit("b2b.first_bit", got_data[0], 1'b1);
        check_bit("b2b.busy", got_busy[0], 1'b1);
        for (int c = 0; c < 9; c++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
        end

        // Reset at bit 3 of 8'hAA together with a load request.
        cycle(1'b0, 1'b1, 32'hAA, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
        end
        cycle(1'b1, 1'b1, 32'hFF, 1'b1);
        check_bit("midrst.ready", got_ready[0], 1'b1);
        check_bit("midrst.line", got_data[0], 1'b1);
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            check_bit("midrst.no_done", got_done[0], 1'b0);
        end

        // Randomized traffic with varying tick rates.
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 200) == 0) mode = int'($urandom_range(0, 2));
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 2) == 0),
                  $urandom(),
                  (mode == 0) ? 1'b1 :
                  (mode == 1) ? ($urandom_range(0, 1) == 0) :
                                ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
